// File: rtl/retire_tracker.sv
// Shadow IF/ID/EX/MEM/WB tracker: mirrors instruction flow through the pipeline,
// reports retiring opcodes and hazard events, and flags program completion.
module retire_tracker #(
  parameter logic [3:0]  NOP_OP       = 4'b1111,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] if_op,
  input  logic       if_valid,
  input  logic       stall,
  input  logic       kill,
  input  logic       prog_end,
  output logic [3:0] ev_op,
  output logic       ev_stall,
  output logic       ev_kill,
  output logic       done
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t DRAIN_MAX = cnt_t'(DRAIN_CYCLES);

  // Empty-pipeline counter: cleared by any live instruction, saturates at DRAIN_MAX.
  function automatic cnt_t drain_sat(input cnt_t cnt, input logic armed, input logic busy);
    if (busy)
      return '0;
    else if (!armed || cnt == DRAIN_MAX)
      return cnt;
    else
      return cnt + cnt_t'(1);
  endfunction

  logic       vld_p0, vld_p1, vld_p2, vld_p3;
  logic [3:0] id_op_p0, ex_op_p1, mem_op_p2, wb_op_p3;
  logic       end_flag;
  cnt_t       drain_cnt;
  cnt_t       drain_nxt;
  logic       busy;

  assign busy      = vld_p0 | vld_p1 | vld_p2 | vld_p3 | if_valid;
  assign drain_nxt = drain_sat(drain_cnt, end_flag, busy);

  // WB op is stored already masked, so ev_op comes straight off a flop.
  assign ev_op = wb_op_p3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      id_op_p0  <= NOP_OP;
      ex_op_p1  <= NOP_OP;
      mem_op_p2 <= NOP_OP;
      wb_op_p3  <= NOP_OP;
      ev_stall  <= 1'b0;
      ev_kill   <= 1'b0;
      end_flag  <= 1'b0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      // IF -> ID -> EX: stall holds ID and bubbles EX; kill squashes only when not stalled
      if (!stall) begin
        vld_p0   <= if_valid & ~kill;
        id_op_p0 <= kill ? NOP_OP : if_op;
        vld_p1   <= vld_p0;
        ex_op_p1 <= id_op_p0;
      end else begin
        vld_p1   <= 1'b0;
        ex_op_p1 <= NOP_OP;
      end
      // EX -> MEM -> WB
      vld_p2    <= vld_p1;
      mem_op_p2 <= ex_op_p1;
      vld_p3    <= vld_p2;
      wb_op_p3  <= vld_p2 ? mem_op_p2 : NOP_OP;
      ev_stall  <= stall;
      ev_kill   <= kill;
      end_flag  <= end_flag | prog_end;
      drain_cnt <= drain_nxt;
      if (drain_nxt == DRAIN_MAX && end_flag)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_retire_tracker.sv
// Randomized and directed bench for retire_tracker, checked against a
// retirement-schedule model (each instruction's retire cycle computed up front).
module tb_retire_tracker;

  localparam logic [3:0] NOP   = 4'b1111;
  localparam int         DRAIN = 4;
  localparam logic [3:0] ADDI = 4'h1, LW = 4'h2, SW = 4'h3, BEQ = 4'h4, BNE = 4'h5, ANDI = 4'h6;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] if_op;
  logic       if_valid, stall, kill, prog_end;
  logic [3:0] ev_op;
  logic       ev_stall, ev_kill, done;

  retire_tracker #(.NOP_OP(NOP), .DRAIN_CYCLES(DRAIN)) dut (
    .CLK(CLK), .RST(RST), .if_op(if_op), .if_valid(if_valid), .stall(stall),
    .kill(kill), .prog_end(prog_end), .ev_op(ev_op), .ev_stall(ev_stall),
    .ev_kill(ev_kill), .done(done)
  );

  always #5 CLK = ~CLK;

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: cycle index = edges since reset; ret_at maps cycle -> opcode on ev_op.
  int         cyc;
  logic       m_id_occ;
  logic [3:0] m_id_op;
  logic [3:0] ret_at [int];
  int         last_ret;
  logic       m_end, m_done, m_pstall, m_pkill;
  int         m_streak;

  task automatic model_reset();
    cyc = 0; m_id_occ = 0; m_id_op = NOP; ret_at.delete(); last_ret = -1;
    m_end = 0; m_done = 0; m_streak = 0; m_pstall = 0; m_pkill = 0;
  endtask

  task automatic model_edge();
    logic busy;
    busy = m_id_occ || (last_ret >= cyc) || if_valid;
    if (busy) m_streak = 0;
    else if (m_end && m_streak < DRAIN) m_streak++;
    if (m_streak == DRAIN) m_done = 1;
    m_end = m_end | prog_end;
    if (!stall) begin
      if (m_id_occ) begin
        ret_at[cyc + 3] = m_id_op;
        last_ret = cyc + 3;
      end
      m_id_occ = if_valid && !kill;
      m_id_op  = if_op;
    end
    m_pstall = stall;
    m_pkill  = kill;
    cyc++;
  endtask

  function automatic logic [3:0] exp_op();
    return ret_at.exists(cyc) ? ret_at[cyc] : NOP;
  endfunction

  task automatic step(input logic v, input logic [3:0] op, input logic s, input logic k, input logic pe);
    if_valid = v; if_op = op; stall = s; kill = k; prog_end = pe;
    @(posedge CLK);
    model_edge();
    #1;
    chk($sformatf("ev_op@%0d", cyc), 32'(ev_op), 32'(exp_op()));
    chk($sformatf("ev_stall@%0d", cyc), 32'(ev_stall), 32'(m_pstall));
    chk($sformatf("ev_kill@%0d", cyc), 32'(ev_kill), 32'(m_pkill));
    chk($sformatf("done@%0d", cyc), 32'(done), 32'(m_done));
  endtask

  task automatic idle();
    step(1'b0, NOP, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    if_valid = 0; if_op = NOP; stall = 0; kill = 0; prog_end = 0;
    RST = 1'b1;
    #1;
    chk("rst_ev_op", 32'(ev_op), 32'(NOP));
    chk("rst_ev_stall", 32'(ev_stall), 32'(0));
    chk("rst_ev_kill", 32'(ev_kill), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  logic [3:0] obs   [0:31];
  logic       obs_b [0:31];
  logic [3:0] seq_ops [0:3];
  int         cnt_a, cnt_b, first;

  initial begin
    n_chk = 0; n_fail = 0;
    seq_ops = '{ADDI, LW, SW, BEQ};
    do_reset();

    // Back-to-back retire sequence
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1'b1, seq_ops[i], 1'b0, 1'b0, 1'b0);
      else idle();
      obs[i] = ev_op;
    end
    chk("seq_pre", 32'(obs[2]), 32'(NOP));
    for (int i = 0; i < 4; i++) chk("seq_op", 32'(obs[3+i]), 32'(seq_ops[i]));
    chk("seq_post", 32'(obs[7]), 32'(NOP));

    // One-cycle stall on LW in ID
    do_reset();
    step(1'b1, LW, 1'b0, 1'b0, 1'b0); obs[0] = ev_op;
    step(1'b0, NOP, 1'b1, 1'b0, 1'b0); obs[1] = ev_op;
    chk("stall_ev_stall", 32'(ev_stall), 32'(1));
    for (int i = 2; i < 7; i++) begin
      idle(); obs[i] = ev_op;
      if (i == 2) chk("stall_ev_stall_clr", 32'(ev_stall), 32'(0));
    end
    cnt_a = 0;
    for (int i = 0; i < 7; i++) if (obs[i] == LW) cnt_a++;
    chk("stall_bubble", 32'(obs[3]), 32'(NOP));
    chk("stall_late", 32'(obs[4]), 32'(LW));
    chk("stall_once", 32'(cnt_a), 32'(1));

    // Kill squashes ANDI in IF, BNE in ID survives
    do_reset();
    step(1'b1, BNE, 1'b0, 1'b0, 1'b0); obs[0] = ev_op;
    step(1'b1, ANDI, 1'b0, 1'b1, 1'b0); obs[1] = ev_op;
    chk("kill_ev_kill", 32'(ev_kill), 32'(1));
    for (int i = 2; i < 7; i++) begin
      idle(); obs[i] = ev_op;
      if (i == 2) chk("kill_ev_kill_clr", 32'(ev_kill), 32'(0));
    end
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 7; i++) begin
      if (obs[i] == ANDI) cnt_a++;
      if (obs[i] == BNE) cnt_b++;
    end
    chk("kill_andi_gone", 32'(cnt_a), 32'(0));
    chk("kill_bne_once", 32'(cnt_b), 32'(1));
    chk("kill_bne_time", 32'(obs[3]), 32'(BNE));

    // Stall and kill together: ID preserved
    do_reset();
    step(1'b1, SW, 1'b0, 1'b0, 1'b0); obs[0] = ev_op;
    step(1'b0, NOP, 1'b1, 1'b1, 1'b0); obs[1] = ev_op;
    chk("both_ev_stall", 32'(ev_stall), 32'(1));
    chk("both_ev_kill", 32'(ev_kill), 32'(1));
    for (int i = 2; i < 7; i++) begin idle(); obs[i] = ev_op; end
    cnt_a = 0;
    for (int i = 0; i < 7; i++) if (obs[i] == SW) cnt_a++;
    chk("both_sw_once", 32'(cnt_a), 32'(1));
    chk("both_sw_time", 32'(obs[4]), 32'(SW));

    // Drain: prog_end with two in flight
    do_reset();
    step(1'b1, ADDI, 1'b0, 1'b0, 1'b0); obs_b[1] = done;
    step(1'b1, LW, 1'b0, 1'b0, 1'b1);   obs_b[2] = done;
    for (int e = 3; e < 31; e++) begin idle(); obs_b[e] = done; end
    first = -1; cnt_a = 0;
    for (int e = 1; e < 31; e++) begin
      if (obs_b[e] && first < 0) first = e;
      if (e >= 10 && !obs_b[e]) cnt_a++;
    end
    chk("drain_rise", 32'(first), 32'(10));
    chk("drain_hold", 32'(cnt_a), 32'(0));
    step(1'b1, SW, 1'b0, 1'b0, 1'b0);
    repeat (3) idle();
    chk("post_done_op", 32'(ev_op), 32'(SW));
    chk("post_done_done", 32'(done), 32'(1));
    repeat (3) idle();

    // Asynchronous reset with three valid stages
    do_reset();
    step(1'b1, ADDI, 1'b0, 1'b0, 1'b0);
    step(1'b1, LW, 1'b0, 1'b0, 1'b0);
    step(1'b1, SW, 1'b0, 1'b0, 1'b0);
    step(1'b1, BEQ, 1'b0, 1'b1, 1'b0);
    chk("mid_pre_op", 32'(ev_op), 32'(ADDI));
    chk("mid_pre_kill", 32'(ev_kill), 32'(1));
    do_reset();
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin idle(); if (ev_op != NOP) cnt_a++; end
    chk("mid_no_leak", 32'(cnt_a), 32'(0));

    // Randomized traffic with idle bursts, occasional prog_end and reset
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic       v, s, k, pe;
      logic [3:0] op;
      if ($urandom_range(0, 299) == 0) do_reset();
      v  = ($urandom_range(0, 3) != 0) && ((i % 100) < 60);
      op = 4'($urandom_range(0, 15));
      s  = ($urandom_range(0, 5) == 0);
      k  = ($urandom_range(0, 6) == 0);
      pe = ($urandom_range(0, 49) == 0);
      step(v, op, s, k, pe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
